mux_sel_ctrl: RTL and testbench

//   Upstream select generator for the board-level 2-bit 4:1 multiplexers.

---
 rtl/mux_sel_ctrl.sv | 108 ++++++++++
 tb/tb_mux_sel_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_ctrl.sv
// Push-button front end for the board mux select: synchronizes and debounces two
// active-low keys, then steps a 2-bit select manually or on a periodic auto-scan.
module mux_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SCAN_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key_n,
    output logic [1:0] sel,
    output logic       sel_chg,
    output logic       auto_mode
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int SCAN_W = $clog2(SCAN_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    logic [1:0] press;

    // Per key: 2-flop synchronizer, debounce counter, accepted level and its delayed copy.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic [1:0]      sync_reg;
            logic [DB_W-1:0] cnt_reg;
            logic            level_reg;
            logic            level_d_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_reg    <= 2'b11;
                    cnt_reg     <= '0;
                    level_reg   <= 1'b1;
                    level_d_reg <= 1'b1;
                end else begin
                    sync_reg    <= {sync_reg[0], key_n[gi]};
                    level_d_reg <= level_reg;
                    if (sync_reg[1] != level_reg) begin
                        if (cnt_reg == DB_LAST) begin
                            level_reg <= sync_reg[1];
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            // Falling edge of the accepted level is a press; releases are ignored.
            assign press[gi] = level_d_reg & ~level_reg;
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [SCAN_W-1:0]  scan_cnt_reg, scan_cnt_next;
    logic [1:0]         sel_reg, sel_next;
    logic               sel_chg_reg, sel_chg_next;
    logic               auto_mode_reg;
    logic               scan_term;
    logic               step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= MANUAL;
            scan_cnt_reg  <= '0;
            sel_reg       <= 2'd0;
            sel_chg_reg   <= 1'b0;
            auto_mode_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            scan_cnt_reg  <= scan_cnt_next;
            sel_reg       <= sel_next;
            sel_chg_reg   <= sel_chg_next;
            auto_mode_reg <= (state_next == AUTO);
        end
    end

    always_comb begin
        state_next = state_reg;
        if (press[1]) begin
            state_next = (state_reg == MANUAL) ? AUTO : MANUAL;
        end
    end

    // A manual step coinciding with the scan terminal count still yields one increment.
    always_comb begin
        scan_term     = (state_reg == AUTO) && (scan_cnt_reg == SCAN_LAST);
        step          = press[0] | scan_term;
        sel_next      = sel_reg + {1'b0, step};
        sel_chg_next  = step;
        scan_cnt_next = '0;
        if ((state_reg == AUTO) && !(|press) && !scan_term) begin
            scan_cnt_next = scan_cnt_reg + 1'b1;
        end
    end

    assign sel       = sel_reg;
    assign sel_chg   = sel_chg_reg;
    assign auto_mode = auto_mode_reg;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Randomized and directed bench for mux_sel_ctrl against a cycle-indexed behavioural model
// (window-based debounce, time-since-restart auto-scan).
module tb_mux_sel_ctrl;
    localparam int D = 4;
    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] key_n;
    logic [1:0] sel;
    logic       sel_chg;
    logic       auto_mode;

    int n_checks = 0;
    int n_errors = 0;

    mux_sel_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .SCAN_CYCLES    (S)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .sel      (sel),
        .sel_chg  (sel_chg),
        .auto_mode(auto_mode)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [1:0] m_pipe0, m_pipe1;
    logic [1:0] m_stab, m_stab_d;
    logic       hist [2][D];
    int         m_sel;
    bit         m_chg;
    bit         m_auto;
    int         cyc = 0;
    int         restart = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs sampled at that edge.
    task automatic model_step(input logic r, input logic [1:0] k);
        logic [1:0] ks, press, stab_old, stab_new;
        bit term, inc, all_diff;
        cyc++;
        if (!r) begin
            m_pipe0 = 2'b11; m_pipe1 = 2'b11;
            m_stab = 2'b11;  m_stab_d = 2'b11;
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < D; j++) hist[i][j] = 1'b1;
            m_sel = 0; m_chg = 0; m_auto = 0;
            restart = cyc;
        end else begin
            ks       = m_pipe1;
            stab_old = m_stab;
            press    = m_stab_d & ~m_stab;
            term     = m_auto && ((cyc - restart) == S);
            inc      = press[0] || term;
            m_sel    = (m_sel + (inc ? 1 : 0)) % 4;
            m_chg    = inc;
            if (press[1]) m_auto = !m_auto;
            if (press[0] || press[1] || term) restart = cyc;
            // A key level is accepted once the last D synchronized samples all disagree with it.
            stab_new = stab_old;
            for (int i = 0; i < 2; i++) begin
                for (int j = D - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
                hist[i][0] = ks[i];
                all_diff = 1'b1;
                for (int j = 0; j < D; j++) if (hist[i][j] == stab_old[i]) all_diff = 1'b0;
                if (all_diff) stab_new[i] = ~stab_old[i];
            end
            m_stab_d = stab_old;
            m_stab   = stab_new;
            m_pipe1  = m_pipe0;
            m_pipe0  = k;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst_n, key_n);
        #1;
        check_val("sel", int'(sel), m_sel);
        check_val("sel_chg", int'(sel_chg), int'(m_chg));
        check_val("auto_mode", int'(auto_mode), int'(m_auto));
    endtask

    task automatic hold(input logic [1:0] k, input int n);
        key_n = k;
        repeat (n) tick();
    endtask

    initial begin
        int first_chg;
        int guard;
        rst_n = 1'b0;
        key_n = 2'b11;

        // 1: reset then idle
        repeat (3) tick();
        rst_n = 1'b1;
        hold(2'b11, 6);
        check_val("idle_sel", int'(sel), 0);

        // 2: clean press on key 0, latency to first sel_chg
        key_n = 2'b10;
        first_chg = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 11) key_n = 2'b11;
            tick();
            if (sel_chg && first_chg == 0) first_chg = i;
        end
        check_val("latency", first_chg, D + 3);
        check_val("after_press_sel", int'(sel), 1);

        // 3: bounce shorter than the debounce window
        repeat (5) begin
            hold(2'b10, 3);
            hold(2'b11, 1);
        end
        hold(2'b11, 12);
        check_val("bounce_sel", int'(sel), 1);

        // 4: four clean presses, wrapping back to the start value
        repeat (4) begin
            hold(2'b10, 6);
            hold(2'b11, 8);
        end
        check_val("wrap_sel", int'(sel), 1);

        // 5: enter auto-scan with a long hold, then leave it
        hold(2'b01, 40);
        hold(2'b11, 10);
        hold(2'b01, 6);
        hold(2'b11, 20);
        check_val("manual_again", int'(auto_mode), 0);

        // 6: enter auto, then time a key 0 press onto the scan terminal count
        hold(2'b01, 6);
        hold(2'b11, 10);
        guard = 0;
        while (((cyc - restart) != (S - D - 3)) && guard < 100) begin
            tick();
            guard++;
        end
        check_val("align_timeout", guard < 100 ? 1 : 0, 1);
        hold(2'b10, 6);
        hold(2'b11, 10);
        hold(2'b00, 6);
        hold(2'b11, 12);
        // reset while key 0 is held; the held key must read as a fresh press afterwards
        key_n = 2'b10;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check_val("rst_sel", int'(sel), 0);
        check_val("rst_auto", int'(auto_mode), 0);
        rst_n = 1'b1;
        hold(2'b10, 10);
        hold(2'b11, 10);
        check_val("fresh_press_sel", int'(sel), 1);

        // randomized key activity with occasional resets
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 12)));
        end
        hold(2'b11, 30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
